// File: rtl/pic_pkg.sv
// Shared defaults and trigger-mode encoding for the interrupt request bank.
package pic_pkg;

    localparam int DEF_NUM_IRQ     = 8;
    localparam int DEF_SYNC_STAGES = 2;

    // Encoding of each trig_level bit.
    localparam logic TRIG_EDGE  = 1'b0;
    localparam logic TRIG_LEVEL = 1'b1;

endpackage

// File: rtl/irq_sync.sv
// One request channel: multi-flop synchronizer followed by a rising-edge detector.
module irq_sync
    import pic_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // History always tracks the synced level, so a mode switch never sees a stale value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~hist_q;

endmodule

// File: rtl/irq_request_bank.sv
// Interrupt request register bank: per-channel edge/level capture, masking,
// acknowledge, sticky overrun flags and a rotating-priority top-request index.
module irq_request_bank
    import pic_pkg::*;
#(
    parameter int NUM_IRQ     = DEF_NUM_IRQ,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int IDX_W       = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] trig_level,
    input  logic [NUM_IRQ-1:0] imr,
    input  logic               clr_valid,
    input  logic [IDX_W-1:0]   clr_idx,
    input  logic [IDX_W-1:0]   rot_base,
    input  logic [NUM_IRQ-1:0] ovr_clr,
    output logic [NUM_IRQ-1:0] irr,
    output logic [NUM_IRQ-1:0] ovr,
    output logic               int_req,
    output logic [IDX_W-1:0]   top_idx
);

    logic [NUM_IRQ-1:0] s;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] edge_set;
    logic [NUM_IRQ-1:0] clr_hit;
    logic [NUM_IRQ-1:0] irr_d, irr_q;
    logic [NUM_IRQ-1:0] ovr_d, ovr_q;
    logic [NUM_IRQ-1:0] trig_prev_q;
    logic               int_req_d, int_req_q;
    logic [IDX_W-1:0]   top_idx_d, top_idx_q;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_chan
        irq_sync #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk    (clk),
            .rst_n  (rst_n),
            .async_i(irq_in[g]),
            .sync_o (s[g]),
            .rise_o (rise[g])
        );
    end

    // Scan upward from the base, wrapping; an out-of-range base starts at channel 0.
    function automatic logic [IDX_W-1:0] find_top(input logic [NUM_IRQ-1:0] req,
                                                  input logic [IDX_W-1:0]   base);
        int               first;
        int               idx;
        logic             found;
        logic [IDX_W-1:0] res;
        first = (int'(base) >= NUM_IRQ) ? 0 : int'(base);
        found = 1'b0;
        res   = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            idx = first + k;
            if (idx >= NUM_IRQ) begin
                idx = idx - NUM_IRQ;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                res   = IDX_W'(idx);
            end
        end
        return res;
    endfunction

    assign edge_set = rise & ~imr;

    // An index beyond the last channel matches nothing.
    always_comb begin
        clr_hit = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr_hit[i] = clr_valid && (int'(clr_idx) == i);
        end
    end

    always_comb begin
        irr_d = irr_q;
        ovr_d = ovr_q & ~ovr_clr;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (trig_level[i] == TRIG_LEVEL) begin
                irr_d[i] = s[i] & ~imr[i] & ~clr_hit[i];
            end else if (trig_prev_q[i] == TRIG_LEVEL) begin
                irr_d[i] = 1'b0;
            end else begin
                // A new edge beats a same-cycle clear; an edge on an uncleared bit is an overrun.
                irr_d[i] = edge_set[i] | (irr_q[i] & ~clr_hit[i]);
                if (edge_set[i] && irr_q[i] && !clr_hit[i]) begin
                    ovr_d[i] = 1'b1;
                end
            end
        end
    end

    assign int_req_d = |irr_d;
    assign top_idx_d = find_top(irr_d, rot_base);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irr_q       <= '0;
            ovr_q       <= '0;
            trig_prev_q <= {NUM_IRQ{TRIG_EDGE}};
            int_req_q   <= 1'b0;
            top_idx_q   <= '0;
        end else begin
            irr_q       <= irr_d;
            ovr_q       <= ovr_d;
            trig_prev_q <= trig_level;
            int_req_q   <= int_req_d;
            top_idx_q   <= top_idx_d;
        end
    end

    assign irr     = irr_q;
    assign ovr     = ovr_q;
    assign int_req = int_req_q;
    assign top_idx = top_idx_q;

endmodule

// File: tb/tb_irq_request_bank.sv
// Directed bench for irq_request_bank (8 channels, 2 sync stages, 4-bit index fields).
module tb_irq_request_bank;

    localparam int NUM_IRQ = 8;
    localparam int SYNC    = 2;
    localparam int IDX_W   = 4;

    logic               clk;
    logic               rst_n;
    logic [NUM_IRQ-1:0] irq_in;
    logic [NUM_IRQ-1:0] trig_level;
    logic [NUM_IRQ-1:0] imr;
    logic               clr_valid;
    logic [IDX_W-1:0]   clr_idx;
    logic [IDX_W-1:0]   rot_base;
    logic [NUM_IRQ-1:0] ovr_clr;
    logic [NUM_IRQ-1:0] irr;
    logic [NUM_IRQ-1:0] ovr;
    logic               int_req;
    logic [IDX_W-1:0]   top_idx;

    int n_cmp  = 0;
    int n_fail = 0;

    irq_request_bank #(
        .NUM_IRQ    (NUM_IRQ),
        .SYNC_STAGES(SYNC),
        .IDX_W      (IDX_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_in),
        .trig_level(trig_level),
        .imr       (imr),
        .clr_valid (clr_valid),
        .clr_idx   (clr_idx),
        .rot_base  (rot_base),
        .ovr_clr   (ovr_clr),
        .irr       (irr),
        .ovr       (ovr),
        .int_req   (int_req),
        .top_idx   (top_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish (observed timeout, required completion)");
        $fatal(1, "watchdog expired");
    end

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic ack(input logic [IDX_W-1:0] idx);
        clr_valid = 1'b1;
        clr_idx   = idx;
        tick(1);
        clr_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        irq_in     = '0;
        trig_level = '0;
        imr        = '0;
        clr_valid  = 1'b0;
        clr_idx    = '0;
        rot_base   = '0;
        ovr_clr    = '0;
        tick(3);
        chk("reset_irr", 32'(irr), 32'h00);
        chk("reset_ovr", 32'(ovr), 32'h00);
        chk("reset_int_req", 32'(int_req), 32'h0);
        chk("reset_top_idx", 32'(top_idx), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // Edge pulse on channel 3: visible after exactly 3 edges, cleared by ack.
        irq_in = 8'h08;
        tick(1);
        irq_in = 8'h00;
        tick(1);
        chk("edge3_not_yet", 32'(irr), 32'h00);
        tick(1);
        chk("edge3_irr", 32'(irr), 32'h08);
        chk("edge3_int_req", 32'(int_req), 32'h1);
        chk("edge3_top_idx", 32'(top_idx), 32'h3);
        ack(4'd3);
        chk("edge3_cleared", 32'(irr), 32'h00);
        chk("edge3_int_req_low", 32'(int_req), 32'h0);

        // Held-high input on channel 2: out-of-range clear ignored, no re-set without new edge.
        irq_in = 8'h04;
        tick(3);
        chk("hold2_set", 32'(irr), 32'h04);
        ack(4'd10);
        chk("clr_out_of_range", 32'(irr), 32'h04);
        ack(4'd2);
        chk("hold2_cleared", 32'(irr), 32'h00);
        tick(4);
        chk("hold2_no_reset", 32'(irr), 32'h00);
        irq_in = 8'h00;
        tick(3);
        irq_in = 8'h04;
        tick(3);
        chk("hold2_new_edge", 32'(irr), 32'h04);
        irq_in = 8'h00;
        ack(4'd2);
        chk("hold2_final_clear", 32'(irr), 32'h00);
        tick(2);

        // Overrun on channel 5 and set-wins-over-clear.
        irq_in = 8'h20;
        tick(1);
        irq_in = 8'h00;
        tick(2);
        chk("ch5_first", 32'(irr), 32'h20);
        chk("ch5_no_ovr", 32'(ovr), 32'h00);
        irq_in = 8'h20;
        tick(1);
        irq_in = 8'h00;
        tick(2);
        chk("ch5_ovr_set", 32'(ovr), 32'h20);
        chk("ch5_irr_kept", 32'(irr), 32'h20);
        ovr_clr = 8'h20;
        tick(1);
        ovr_clr = 8'h00;
        chk("ch5_ovr_clr", 32'(ovr), 32'h00);
        irq_in = 8'h20;
        tick(1);
        irq_in = 8'h00;
        tick(1);
        ack(4'd5);
        chk("ch5_set_wins_irr", 32'(irr), 32'h20);
        chk("ch5_set_wins_ovr", 32'(ovr), 32'h00);
        ack(4'd5);
        chk("ch5_cleared", 32'(irr), 32'h00);

        // Masked edge discarded; set bit survives a later mask.
        imr    = 8'h40;
        irq_in = 8'h40;
        tick(1);
        irq_in = 8'h00;
        tick(2);
        chk("masked_edge", 32'(irr), 32'h00);
        imr = 8'h00;
        tick(2);
        chk("masked_not_latched", 32'(irr), 32'h00);
        irq_in = 8'h02;
        tick(1);
        irq_in = 8'h00;
        tick(2);
        chk("ch1_set", 32'(irr), 32'h02);
        imr = 8'h02;
        tick(1);
        chk("ch1_mask_keeps", 32'(irr), 32'h02);
        ack(4'd1);
        chk("ch1_cleared", 32'(irr), 32'h00);
        imr = 8'h00;
        tick(1);

        // Level mode with channel 0 masked.
        trig_level = 8'hFF;
        imr        = 8'h01;
        irq_in     = 8'h03;
        tick(3);
        chk("level_irr", 32'(irr), 32'h02);
        chk("level_top_idx", 32'(top_idx), 32'h1);
        ack(4'd1);
        chk("level_clr_cycle", 32'(irr), 32'h00);
        tick(1);
        chk("level_back", 32'(irr), 32'h02);
        chk("level_no_ovr", 32'(ovr), 32'h00);
        irq_in = 8'h01;
        tick(2);
        chk("level_drop_early", 32'(irr), 32'h02);
        tick(1);
        chk("level_drop", 32'(irr), 32'h00);

        // Level -> edge switch clears irr and produces no spurious edge.
        irq_in = 8'h05;
        tick(3);
        chk("level_ch2", 32'(irr), 32'h04);
        trig_level = 8'h00;
        tick(1);
        chk("to_edge_cleared", 32'(irr), 32'h00);
        tick(3);
        chk("to_edge_no_spurious", 32'(irr), 32'h00);
        imr    = 8'h00;
        irq_in = 8'h00;
        tick(3);

        // Rotating priority.
        trig_level = 8'hFF;
        irq_in     = 8'h81;
        rot_base   = 4'd0;
        tick(3);
        chk("prio_irr", 32'(irr), 32'h81);
        chk("prio_base0", 32'(top_idx), 32'h0);
        rot_base = 4'd1;
        tick(1);
        chk("prio_base1", 32'(top_idx), 32'h7);
        rot_base = 4'd9;
        tick(1);
        chk("prio_base9", 32'(top_idx), 32'h0);
        rot_base = 4'd8;
        tick(1);
        chk("prio_base8", 32'(top_idx), 32'h0);
        rot_base = 4'd7;
        tick(1);
        chk("prio_base7", 32'(top_idx), 32'h7);
        irq_in   = 8'h24;
        rot_base = 4'd3;
        tick(3);
        chk("prio_24_base3", 32'(top_idx), 32'h5);
        rot_base = 4'd6;
        tick(1);
        chk("prio_24_base6", 32'(top_idx), 32'h2);
        rot_base   = 4'd0;
        irq_in     = 8'h00;
        trig_level = 8'h00;
        tick(4);
        chk("back_to_edge_idle", 32'(irr), 32'h00);

        // Load irr=0xFF, ovr=0x0F, then reset mid-cycle.
        irq_in = 8'hFF;
        tick(1);
        irq_in = 8'h00;
        tick(2);
        chk("all_set", 32'(irr), 32'hFF);
        irq_in = 8'h0F;
        tick(1);
        irq_in = 8'h00;
        tick(2);
        chk("ovr_0f", 32'(ovr), 32'h0F);
        irq_in = 8'h10;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_irr", 32'(irr), 32'h00);
        chk("async_rst_ovr", 32'(ovr), 32'h00);
        chk("async_rst_int_req", 32'(int_req), 32'h0);
        chk("async_rst_top_idx", 32'(top_idx), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk("post_rst_early", 32'(irr), 32'h00);
        tick(1);
        chk("post_rst_irr", 32'(irr), 32'h10);
        chk("post_rst_int_req", 32'(int_req), 32'h1);
        chk("post_rst_top_idx", 32'(top_idx), 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_request_bank.md
IRQ_REQUEST_BANK -- requirements
Module: irq_request_bank

Interface
REQ-001 Parameter NUM_IRQ, default 8, meaning number of request channels (2..32).
REQ-002 Parameter SYNC_STAGES, default 2, meaning synchronizer depth per channel (2..4).
REQ-003 Parameter IDX_W, default $clog2(NUM_IRQ), meaning width of channel index fields.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 irq_in  input  NUM_IRQ  raw asynchronous request lines.
REQ-007 trig_level  input  NUM_IRQ  per-channel mode: 1 = level-triggered, 0 = edge-triggered.
REQ-008 imr  input  NUM_IRQ  per-channel mask: 1 = masked.
REQ-009 clr_valid  input  1  one-cycle strobe that clears one request (acknowledge).
REQ-010 clr_idx  input  IDX_W  channel cleared by clr_valid.
REQ-011 rot_base  input  IDX_W  channel holding highest priority; priority descends with increasing index, wrapping.
REQ-012 ovr_clr  input  NUM_IRQ  write-one-to-clear for overrun flags.
REQ-013 irr  output  NUM_IRQ  registered request register.
REQ-014 ovr  output  NUM_IRQ  sticky per-channel overrun flags.
REQ-015 int_req  output  1  registered: any irr bit set.
REQ-016 top_idx  output  IDX_W  registered index of highest-priority set irr bit; valid only when int_req=1.

Function
REQ-017 Each irq_in bit SHALL pass through SYNC_STAGES flops; the last stage is the synced level s[i].
REQ-018 Edge mode: rising edge = s[i]=1 with previous synced value 0; an unmasked edge SHALL set irr[i] at the next clk edge.
REQ-019 Edge mode: a masked edge SHALL be discarded (not latched later on unmask); an already-set irr[i] SHALL remain set when imr[i] rises.
REQ-020 Edge mode: irr[i] SHALL hold until clr_valid with clr_idx=i; a held-high input SHALL NOT re-set the bit without a new low-to-high transition.
REQ-021 Edge mode: same-cycle unmasked edge and clear on channel i -> irr[i] stays 1 (set wins), ovr[i] unchanged.
REQ-022 Edge mode: unmasked edge while irr[i]=1 and no clear of i -> ovr[i] set; irr[i] stays 1.
REQ-023 Level mode: irr[i] SHALL equal s[i] & ~imr[i] each cycle, except a cycle with clr_valid on i forces irr[i]=0 for that one cycle; ovr[i] is never set in level mode.
REQ-024 ovr_clr[i]=1 SHALL clear ovr[i] next cycle; simultaneous overrun set on i wins.
REQ-025 clr_idx >= NUM_IRQ SHALL be ignored.
REQ-026 Mode change level->edge: irr[i] cleared next cycle; edge history loaded with current s[i] so no spurious edge. Edge->level: irr[i] follows REQ-023 from next cycle.
REQ-027 int_req and top_idx SHALL be computed from the updated irr value and registered in the same cycle as irr (zero added latency vs irr).
REQ-028 top_idx search: start at rot_base, scan ascending indices modulo NUM_IRQ, first set bit wins; rot_base >= NUM_IRQ treated as 0.
REQ-029 Total latency irq_in rising edge -> irr/int_req high = SYNC_STAGES+1 cycles.

Reset
REQ-030 rst_n low SHALL asynchronously clear all synchronizer stages, edge history, irr, ovr, int_req and top_idx to 0.
REQ-031 After rst_n deasserts, an input already high SHALL produce one edge after synchronization (history is 0).
REQ-032 Reset mid-operation SHALL discard pending requests and overrun flags without emitting glitches on outputs.

Structure
REQ-033 Package pic_pkg SHALL hold default NUM_IRQ, SYNC_STAGES, and the trigger-mode encoding constants (TRIG_EDGE=0, TRIG_LEVEL=1).
REQ-034 Sub-module irq_sync (synchronizer plus edge detector, one channel, parameter SYNC_STAGES) SHALL be instantiated NUM_IRQ times via generate.
REQ-035 Rotating priority search SHALL be a combinational function inside irq_request_bank, not a separate module.

Verification
REQ-036 NUM_IRQ=8, edge mode, imr=0: pulse irq_in[3] -> irr=0x08, int_req=1, top_idx=3 after 3 cycles; clr_valid,clr_idx=3 -> irr=0x00 next cycle.
REQ-037 Edge mode, irq_in[2] held high, irr[2] set, clear issued -> irr[2] stays 0 until irq_in[2] drops and rises again.
REQ-038 Edge, irr[5]=1, second edge on 5 without clear -> ovr=0x20; ovr_clr=0x20 -> ovr=0x00; edge coinciding with clear of 5 -> irr[5]=1, ovr=0x00.
REQ-039 Level mode, imr=0x01, irq_in=0x03 -> irr=0x02; drop irq_in[1] -> irr=0x00 after SYNC_STAGES+1 cycles.
REQ-040 irr=0x81, rot_base=0 -> top_idx=0; rot_base=1 -> top_idx=7; rot_base=9 (NUM_IRQ=8) -> top_idx=0.
REQ-041 rst_n asserted asynchronously mid-cycle with irr=0xFF, ovr=0x0F -> all outputs 0 immediately; irq_in=0x10 held through release -> irr=0x10 after SYNC_STAGES+1 cycles.
